// File: rtl/link_rr_arbiter.sv
// Round-robin burst arbiter for a shared output link.
// One channel owns the link per grant; it is released on last, beat cap, timeout or withdraw.
module link_rr_arbiter #(
   parameter int NUM_CH    = 4,
   parameter int IDX_W     = 2,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 16,
   parameter int GAP_CYC   = 1,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   input  logic              link_vld,
   input  logic              link_rdy,
   input  logic              link_last,
   output logic [NUM_CH-1:0] gnt,
   output logic [IDX_W-1:0]  gnt_idx,
   output logic              gnt_vld,
   output logic [CNT_W-1:0]  beat_cnt,
   output logic              trunc_pls,
   output logic              tmo_pls
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;

   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W:0]   scan;
   logic [IDX_W-1:0] scan_idx;

   logic accept;
   logic at_cap;
   logic quiet_end;
   logic gap_end;
   logic rel_last;
   logic rel_cap;
   logic rel_wd;
   logic rel_tmo;
   logic rel;
   logic load;
   logic trunc_nxt;
   logic tmo_nxt;

   // Scan from the highest offset down so the channel nearest ptr wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan     = '0;
      scan_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         scan = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (scan >= (IDX_W + 1)'(NUM_CH))
            scan = scan - (IDX_W + 1)'(NUM_CH);
         scan_idx = scan[IDX_W-1:0];
         if (req[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   assign accept    = (state == S_GRANT) & link_vld & link_rdy;
   assign at_cap    = beat_cnt == CNT_W'(MAX_BEATS - 1);
   assign quiet_end = tmo_cnt == TMO_W'(TIMEOUT - 1);
   assign gap_end   = gap_cnt == GAP_W'(GAP_CYC - 1);

   assign rel_last = accept & link_last;
   assign rel_cap  = accept & at_cap;
   assign rel_wd   = (state == S_GRANT) & ~req[gnt_idx] & ~link_vld;
   assign rel_tmo  = (state == S_GRANT) & ~accept & quiet_end;
   assign rel      = rel_last | rel_cap | rel_wd | rel_tmo;
   assign load     = (state == S_IDLE) & pick_vld;

   assign ptr_nxt = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
   assign gnt_vld = |gnt;

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (load)    state_nxt = S_GRANT;
         S_GRANT: if (rel)     state_nxt = S_GAP;
         S_GAP:   if (gap_end) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A normal last wins over the cap; any release wins over the timeout.
   always_comb begin
      trunc_nxt = 1'b0;
      tmo_nxt   = 1'b0;
      priority case (1'b1)
         rel_last: trunc_nxt = 1'b0;
         rel_cap:  trunc_nxt = 1'b1;
         rel_wd:   tmo_nxt   = 1'b0;
         rel_tmo:  tmo_nxt   = 1'b1;
         default:  tmo_nxt   = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         gnt_idx   <= '0;
         beat_cnt  <= '0;
         ptr       <= '0;
         tmo_cnt   <= '0;
         gap_cnt   <= '0;
         trunc_pls <= 1'b0;
         tmo_pls   <= 1'b0;
      end else begin
         trunc_pls <= trunc_nxt;
         tmo_pls   <= tmo_nxt;
         if (load) begin
            gnt      <= NUM_CH'(1) << pick_idx;
            gnt_idx  <= pick_idx;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
         end
         if (accept)
            beat_cnt <= beat_cnt + 1'b1;
         if (state == S_GRANT)
            tmo_cnt <= accept ? '0 : tmo_cnt + 1'b1;
         if (rel) begin
            gnt     <= '0;
            ptr     <= ptr_nxt;
            gap_cnt <= '0;
         end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_link_rr_arbiter.sv
// Bench for link_rr_arbiter: directed bursts checked against a behavioural model
// every cycle, plus literal expectations at the key points of each scenario.
module tb_link_rr_arbiter;

   localparam int N   = 4;
   localparam int IW  = 2;
   localparam int MB  = 4;
   localparam int CW  = 16;
   localparam int GAP = 2;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic          vld = 1'b0;
   logic          rdy = 1'b0;
   logic          last = 1'b0;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_vld;
   logic [CW-1:0] beat_cnt;
   logic          trunc_pls;
   logic          tmo_pls;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   link_rr_arbiter #(
      .NUM_CH(N), .IDX_W(IW), .MAX_BEATS(MB),
      .CNT_W(CW), .GAP_CYC(GAP), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .req(req),
      .link_vld(vld), .link_rdy(rdy), .link_last(last),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld),
      .beat_cnt(beat_cnt), .trunc_pls(trunc_pls), .tmo_pls(tmo_pls)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: owner (-1 = none), beats in grant, cycles since last accept,
   // blanking cycles left after a release, and the round-robin start point.
   int m_own = -1;
   int m_beats = 0;
   int m_quiet = 0;
   int m_hold = 0;
   int m_ptr = 0;
   bit m_tr = 0;
   bit m_to = 0;
   bit m_ok = 0;
   bit m_acc;
   bit m_done;

   always @(posedge clk) begin
      if (rst) begin
         m_own = -1; m_beats = 0; m_quiet = 0; m_hold = 0;
         m_ptr = 0; m_tr = 0; m_to = 0; m_ok = 1;
      end else begin
         m_tr = 0;
         m_to = 0;
         if (m_own >= 0) begin
            m_acc = vld && rdy;
            m_done = 0;
            if (m_acc) begin
               m_beats++;
               m_quiet = 0;
            end else begin
               m_quiet++;
            end
            if (m_acc && last) m_done = 1;
            else if (m_acc && m_beats == MB) begin m_done = 1; m_tr = 1; end
            else if (!req[IW'(m_own)] && !vld) m_done = 1;
            else if (m_quiet == TMO) begin m_done = 1; m_to = 1; end
            if (m_done) begin
               m_ptr = (m_own + 1) % N;
               m_own = -1;
               m_hold = GAP;
            end
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (req != '0) begin
            for (int i = N - 1; i >= 0; i--)
               if (req[IW'((m_ptr + i) % N)]) m_own = (m_ptr + i) % N;
            m_beats = 0;
            m_quiet = 0;
         end
      end
   end

   logic [N-1:0] e_gnt;
   always @(negedge clk) begin
      if (m_ok) begin
         e_gnt = (m_own >= 0) ? (N'(1) << m_own) : '0;
         chk("cmp_gnt", 32'(gnt), 32'(e_gnt));
         chk("cmp_vld", 32'(gnt_vld), 32'(m_own >= 0));
         if (m_own >= 0) chk("cmp_idx", 32'(gnt_idx), m_own);
         chk("cmp_beats", 32'(beat_cnt), m_beats);
         chk("cmp_trunc", 32'(trunc_pls), 32'(m_tr));
         chk("cmp_tmo", 32'(tmo_pls), 32'(m_to));
      end
   end

   task automatic wait_vld(input int maxc);
      bit ok;
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (gnt_vld === 1'b1) begin
            ok = 1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL wait_gnt: got no grant, expected one within %0d cycles", maxc);
      end
   endtask

   int lows;
   int order[5] = '{0, 1, 2, 3, 0};
   int bc_exp[5] = '{1, 1, 2, 2, 3};

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_vld", 32'(gnt_vld), 32'h0);
      chk("rst_beats", 32'(beat_cnt), 32'h0);
      chk("rst_pls", 32'({trunc_pls, tmo_pls}), 32'h0);

      // 1: two requesters, ch0 first, then ch2 after the turnaround
      rst = 1'b0;
      req = 4'b0101;
      @(negedge clk);
      chk("t1_gnt0", 32'(gnt), 32'h1);
      vld = 1'b1; rdy = 1'b1; last = 1'b0;
      @(negedge clk);
      chk("t1_beat1", 32'(beat_cnt), 32'd1);
      last = 1'b1; req = 4'b0100;
      @(negedge clk);
      chk("t1_rel", 32'(gnt), 32'h0);
      chk("t1_beats", 32'(beat_cnt), 32'd2);
      vld = 1'b0; last = 1'b0;
      lows = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (gnt_vld === 1'b1) break;
         lows++;
      end
      chk("t1_lowcyc", lows, 32'd3);
      chk("t1_gnt2", 32'(gnt), 32'h4);
      req = 4'b0000;
      @(negedge clk);
      chk("t1_wd", 32'(gnt), 32'h0);
      repeat (GAP + 1) @(negedge clk);

      // 2: all requesting, single-beat bursts
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 4'b1111; vld = 1'b1; rdy = 1'b1; last = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_vld(10);
         chk("t2_order", 32'(gnt_idx), order[k]);
         @(negedge clk);
         chk("t2_duty", 32'(gnt_vld), 32'h0);
      end
      req = 4'b0000; vld = 1'b0; last = 1'b0;
      repeat (GAP + 2) @(negedge clk);

      // 3: beat cap without last, then last on the cap beat
      req = 4'b0010;
      wait_vld(10);
      chk("t3_gnt", 32'(gnt), 32'h2);
      vld = 1'b1; rdy = 1'b1; last = 1'b0;
      repeat (3) @(negedge clk);
      chk("t3_mid", 32'(beat_cnt), 32'd3);
      @(negedge clk);
      chk("t3_rel", 32'(gnt), 32'h0);
      chk("t3_beats", 32'(beat_cnt), 32'd4);
      chk("t3_trunc", 32'(trunc_pls), 32'h1);
      vld = 1'b0; req = 4'b0000;
      @(negedge clk);
      chk("t3_trunc_once", 32'(trunc_pls), 32'h0);
      req = 4'b0100;
      wait_vld(10);
      chk("t3b_gnt", 32'(gnt), 32'h4);
      vld = 1'b1; rdy = 1'b1; last = 1'b0;
      repeat (3) @(negedge clk);
      last = 1'b1;
      @(negedge clk);
      chk("t3b_rel", 32'(gnt), 32'h0);
      chk("t3b_beats", 32'(beat_cnt), 32'd4);
      chk("t3b_notrunc", 32'(trunc_pls), 32'h0);
      vld = 1'b0; last = 1'b0; req = 4'b0000;

      // 4: silent owner times out, next requester follows
      req = 4'b1001;
      wait_vld(10);
      chk("t4_gnt", 32'(gnt), 32'h8);
      repeat (7) @(negedge clk);
      chk("t4_hold", 32'(gnt), 32'h8);
      chk("t4_notmo", 32'(tmo_pls), 32'h0);
      @(negedge clk);
      chk("t4_rel", 32'(gnt), 32'h0);
      chk("t4_tmo", 32'(tmo_pls), 32'h1);
      req = 4'b0001;
      @(negedge clk);
      chk("t4_tmo_once", 32'(tmo_pls), 32'h0);
      wait_vld(10);
      chk("t4_next", 32'(gnt), 32'h1);
      req = 4'b0000;
      @(negedge clk);
      chk("t4_wd", 32'(gnt), 32'h0);

      // 5: ready toggling, only accepts count
      req = 4'b0010;
      wait_vld(10);
      chk("t5_gnt", 32'(gnt), 32'h2);
      vld = 1'b1;
      for (int k = 0; k < 5; k++) begin
         rdy = (k % 2 == 0);
         last = (k == 4);
         @(negedge clk);
         chk("t5_beats", 32'(beat_cnt), bc_exp[k]);
      end
      chk("t5_rel", 32'(gnt), 32'h0);
      chk("t5_notrunc", 32'(trunc_pls), 32'h0);
      vld = 1'b0; rdy = 1'b0; last = 1'b0; req = 4'b0000;

      // 6: reset in the middle of a burst
      req = 4'b0101;
      wait_vld(10);
      chk("t6_gnt", 32'(gnt), 32'h4);
      vld = 1'b1; rdy = 1'b1; last = 1'b0;
      repeat (2) @(negedge clk);
      chk("t6_beats", 32'(beat_cnt), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_gnt_rst", 32'(gnt), 32'h0);
      chk("t6_beats_rst", 32'(beat_cnt), 32'h0);
      chk("t6_pls_rst", 32'({trunc_pls, tmo_pls}), 32'h0);
      rst = 1'b0; vld = 1'b0;
      @(negedge clk);
      chk("t6_regnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
